ppwm_mc: RTL and testbench

Multi-channel programmable PWM generator: the parametrised successor of the single-channel serial-programmed PWM top. One serial input line carries addressed frames that set a per-channel compare value. All channels share one period counter. New values are double-buffered and only take effect at a period boundary. The block sits at the chip top, between the serial programming pin and the PWM output pins.

---
 rtl/ppwm_mc_pkg.sv | 14 +
 rtl/ppwm_mc_rx.sv | 68 ++++++
 rtl/ppwm_mc.sv | 97 +++++++++
 tb/tb_ppwm_mc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ppwm_mc_pkg.sv
// Shared types and helpers for the multi-channel PWM block and its frame receiver.
package ppwm_mc_pkg;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_t;

  // Channel-index field width: never narrower than one bit, even for a single channel.
  function automatic int calc_idx_w(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/ppwm_mc_rx.sv
// Serial frame receiver: start bit, then IDX_W index bits and VAL_W value bits, MSB-first.
// The write strobe fires combinationally on the cycle the last payload bit is on the line.
module ppwm_mc_rx
  import ppwm_mc_pkg::*;
#(
  parameter int IDX_W = 2,
  parameter int VAL_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_data,
  output logic             o_wr_vld,
  output logic [IDX_W-1:0] o_wr_idx,
  output logic [VAL_W-1:0] o_wr_val
);

  localparam int F   = IDX_W + VAL_W;
  localparam int BCW = $clog2(F);

  rx_state_t      r_state;
  rx_state_t      w_state_nxt;
  logic [BCW-1:0] r_bit_cnt;
  logic [BCW-1:0] w_bit_cnt_nxt;
  logic [F-2:0]   r_sr;
  logic [F-1:0]   w_word;

  // The final bit is taken straight from the line so the write lands with no extra cycle.
  assign w_word   = {r_sr, i_data};
  assign o_wr_idx = w_word[F-1:VAL_W];
  assign o_wr_val = w_word[VAL_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RX_IDLE;
      r_bit_cnt <= '0;
      r_sr      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      if (r_state == RX_SHIFT) begin
        r_sr <= w_word[F-2:0];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    o_wr_vld      = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (i_data) begin
          w_state_nxt   = RX_SHIFT;
          w_bit_cnt_nxt = '0;
        end
      end
      RX_SHIFT: begin
        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        if (r_bit_cnt == BCW'(F - 1)) begin
          o_wr_vld    = 1'b1;
          w_state_nxt = RX_IDLE;
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/ppwm_mc.sv
// Multi-channel PWM with serially programmed, period-aligned double-buffered compare values.
// Optional PPWM_MC_PHASE_EN staggers each channel's counter by k * (period / NUM_CH).
module ppwm_mc
  import ppwm_mc_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int COUNTER_WIDTH = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_i,
  output logic [NUM_CH-1:0] data_o,
  output logic              period_start_o,
  output logic              programmed_o
);

  localparam int IDX_W   = calc_idx_w(NUM_CH);
  localparam int CW      = COUNTER_WIDTH;
  localparam int PH_STEP = (1 << CW) / NUM_CH;

  logic              w_wr_vld;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [CW-1:0]     w_wr_val;
  logic [NUM_CH-1:0] w_wr_sel;
  logic [NUM_CH-1:0] r_written;
  logic [NUM_CH-1:0] w_written_nxt;
  logic              w_complete;
  logic              w_load;
  logic [CW-1:0]     r_shadow     [NUM_CH];
  logic [CW-1:0]     w_shadow_nxt [NUM_CH];
  logic [CW-1:0]     r_active     [NUM_CH];
  logic [CW-1:0]     r_cnt;
  logic              r_prog;

  ppwm_mc_rx #(
    .IDX_W (IDX_W),
    .VAL_W (CW)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_data   (data_i),
    .o_wr_vld (w_wr_vld),
    .o_wr_idx (w_wr_idx),
    .o_wr_val (w_wr_val)
  );

  // Out-of-range indices match no channel, so such frames are dropped here.
  always_comb begin
    w_wr_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_wr_sel[k]     = w_wr_vld && (w_wr_idx == IDX_W'(k));
      w_shadow_nxt[k] = w_wr_sel[k] ? w_wr_val : r_shadow[k];
    end
  end

  assign w_written_nxt = r_written | w_wr_sel;
  assign w_complete    = !r_prog && (|w_wr_sel) && (&w_written_nxt);
  assign w_load        = w_complete || (r_prog && (r_cnt == '1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_written <= '0;
      r_prog    <= 1'b0;
      r_cnt     <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else begin
      r_written <= w_written_nxt;
      r_prog    <= r_prog | w_complete;
      if (r_prog) begin
        r_cnt <= r_cnt + 1'b1;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        r_shadow[k] <= w_shadow_nxt[k];
        if (w_load) begin
          r_active[k] <= w_shadow_nxt[k];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CW-1:0] w_cnt_k;
`ifdef PPWM_MC_PHASE_EN
    assign w_cnt_k = r_cnt - CW'(k * PH_STEP);
`else
    assign w_cnt_k = r_cnt;
`endif
    assign data_o[k] = r_prog & (w_cnt_k < r_active[k]);
  end

  assign period_start_o = r_prog & (r_cnt == '0);
  assign programmed_o   = r_prog;

endmodule

// File: tb/tb_ppwm_mc.sv
// Bench for ppwm_mc (4 channels, 16-cycle period): planned frame schedule, event-list model, period scoreboard.
module tb_ppwm_mc;

  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int PER = 16;
  localparam int F   = 6;
  localparam int FL  = 7;
`ifdef PPWM_MC_PHASE_EN
  localparam bit PHASE = 1'b1;
`else
  localparam bit PHASE = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]                start;
    logic [NCH-1:0][PER-1:0]    pat;
  } rec_t;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           data_i = 1'b0;
  logic [NCH-1:0] data_o;
  logic           period_start_o;
  logic           programmed_o;

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_busy = 1'b0;
  rec_t exp_q[$];
  int   m_vis[$], m_ch[$], m_val[$];
  int   p_start[$], p_ch[$], p_val[$];
  int   init_val [NCH] = '{0, 4, 8, 15};

  rec_t                    mon_r;
  logic [NCH-1:0][PER-1:0] mon_got;
  logic [PER-1:0]          mon_ps;

  ppwm_mc #(.NUM_CH(NCH), .COUNTER_WIDTH(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_i         (data_i),
    .data_o         (data_o),
    .period_start_o (period_start_o),
    .programmed_o   (programmed_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({data_o, period_start_o, programmed_o});
  endfunction

  // Value seen by a channel in the period starting at cycle s: the latest write visible by then.
  function automatic int val_at(input int ch, input int s);
    int v;
    v = -1;
    foreach (m_vis[i]) if (m_ch[i] == ch && m_vis[i] <= s) v = m_val[i];
    return v;
  endfunction

  function automatic logic [PER-1:0] pattern(input int ch, input int v);
    logic [PER-1:0] p;
    int pos;
    p = '0;
    for (int j = 0; j < PER; j++) begin
      pos  = PHASE ? (((j - ch * (PER / NCH)) % PER) + PER) % PER : j;
      p[j] = (pos < v);
    end
    return p;
  endfunction

  task automatic plan_add(input int start, input int ch, input int v);
    p_start.push_back(start); p_ch.push_back(ch); p_val.push_back(v);
    m_vis.push_back(start + FL); m_ch.push_back(ch); m_val.push_back(v);
  endtask

  // Called and returns just after a rising edge.
  task automatic send_frame(input int ch, input int v);
    logic [F:0] fr;
    fr = {1'b1, 2'(ch), 4'(v)};
    for (int i = F; i >= 0; i--) begin
      data_i = fr[i];
      @(posedge clk); #1;
    end
    data_i = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    int budget;
    budget = 3000;
    while ((exp_q.size() != 0 || mon_busy) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("drain_timeout", 64'(budget == 0), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", outs(), 64'd0);
    m_vis.delete(); m_ch.delete(); m_val.delete(); exp_q.delete();
    repeat (4) begin
      @(posedge clk); #1;
      data_i = 1'($urandom_range(0, 1));
      chk("reset_hold_outputs", outs(), 64'd0);
    end
    data_i = 1'b0;
    rst_n  = 1'b1;
  endtask

  task automatic run_prog(input bit rev, input bit updates);
    int c0, ts, t, np, ch;
    rec_t r;
    c0 = cyc + 2;
    for (int i = 0; i < NCH; i++) begin
      ch = rev ? NCH - 1 - i : i;
      plan_add(c0 + FL * i, ch, init_val[ch]);
    end
    ts = c0 + NCH * FL;
    if (updates) begin
      plan_add(ts + PER - 1, 1, 12);
      plan_add(ts + 3 * PER + 9, 1, (12 + int'($urandom_range(1, 15))) % PER);
      t = ts + 4 * PER;
      for (int i = 0; i < 6; i++) begin
        t += int'($urandom_range(0, 20));
        plan_add(t, int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, PER - 1)));
        t += FL;
      end
    end
    np = (m_vis[$] - ts) / PER + 2;
    for (int p = 0; p < np; p++) begin
      r.start = 32'(ts + PER * p);
      for (int k = 0; k < NCH; k++) r.pat[k] = pattern(k, val_at(k, ts + PER * p));
      exp_q.push_back(r);
    end
    while (p_start.size() != 0) begin
      wait_until(p_start[0]);
      send_frame(p_ch[0], p_val[0]);
      void'(p_start.pop_front()); void'(p_ch.pop_front()); void'(p_val.pop_front());
    end
    wait_drain();
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && period_start_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_period_start", 64'(period_start_o), 64'd0);
        end else begin
          mon_r    = exp_q.pop_front();
          mon_busy = 1'b1;
          chk("period_start_cycle", 64'(cyc), 64'(mon_r.start));
          chk("programmed_at_start", 64'(programmed_o), 64'd1);
          for (int j = 0; j < PER; j++) begin
            if (j > 0) @(negedge clk);
            mon_ps[j] = period_start_o;
            for (int k = 0; k < NCH; k++) mon_got[k][j] = data_o[k];
          end
          for (int k = 0; k < NCH; k++)
            chk($sformatf("ch%0d_duty_pattern", k), 64'(mon_got[k]), 64'(mon_r.pat[k]));
          chk("pulse_pattern", 64'(mon_ps), 64'd1);
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n  = 1'b0;
    data_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      data_i = ~data_i;
      chk("reset_outputs", outs(), 64'd0);
    end
    data_i = 1'b0;
    rst_n  = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      chk("idle_outputs", outs(), 64'd0);
    end

    run_prog(1'b0, 1'b1);
    do_reset();

    repeat (5) begin @(posedge clk); #1; end
    for (int ch = 0; ch < NCH - 1; ch++) send_frame(ch, int'($urandom_range(0, PER - 1)));
    repeat (200) begin
      @(posedge clk); #1;
      chk("partial_program_outputs", outs(), 64'd0);
    end

    data_i = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      data_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    do_reset();
    repeat (3) begin @(posedge clk); #1; end
    run_prog(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
